// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the program counter and fetches one instruction
// word per IR_LOAD request, with a 16-cycle memory timeout.
module fetch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        IR_LOAD,
  input  logic        INCR_PC,
  input  logic        BE,
  input  logic [15:0] target,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  output logic [15:0] pc,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        stall,
  output logic        fetch_err
);

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t     state;
  logic [3:0] wcnt;

  // pc sequencing runs independently of the fetch FSM; the fetch snapshots pc
  // into mem_addr/instr_pc so later pc moves never disturb an in-flight read.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      wcnt      <= 4'd0;
      pc        <= 16'h0000;
      instr     <= 16'h0000;
      instr_pc  <= 16'h0000;
      mem_addr  <= 16'h0000;
      mem_rd    <= 1'b0;
      stall     <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      if (BE) begin
        pc <= target;
      end else if (INCR_PC) begin
        pc <= pc + 16'd1;
      end

      case (state)
        IDLE: begin
          if (IR_LOAD) begin
            state    <= FETCH;
            mem_addr <= pc;
            instr_pc <= pc;
            wcnt     <= 4'd0;
            mem_rd   <= 1'b1;
            stall    <= 1'b1;
          end
        end

        FETCH: begin
          if (mem_ready) begin
            instr  <= mem_rdata;
            state  <= IDLE;
            mem_rd <= 1'b0;
            stall  <= 1'b0;
          end else if (wcnt == 4'd15) begin
            // Sixteenth unready cycle: give up and hand the decoder a zero word.
            instr     <= 16'h0000;
            fetch_err <= 1'b1;
            state     <= IDLE;
            mem_rd    <= 1'b0;
            stall     <= 1'b0;
          end else begin
            wcnt <= wcnt + 4'd1;
          end
        end

        default: begin
          state  <= IDLE;
          mem_rd <= 1'b0;
          stall  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        IR_LOAD;
  logic        INCR_PC;
  logic        BE;
  logic [15:0] target;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [15:0] pc;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        stall;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clk       (clk),
    .reset     (reset),
    .IR_LOAD   (IR_LOAD),
    .INCR_PC   (INCR_PC),
    .BE        (BE),
    .target    (target),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .pc        (pc),
    .instr     (instr),
    .instr_pc  (instr_pc),
    .stall     (stall),
    .fetch_err (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; IR_LOAD = 1'b0; INCR_PC = 1'b1; BE = 1'b1; target = 16'h1234;
    mem_rdata = 16'hFFFF; mem_ready = 1'b1;
    step(); step();
    checks++;
    if (pc !== 16'h0000) begin errors++; $display("[TB] FAIL reset_pc: got %h expected 0000", pc); end
    checks++;
    if ({mem_rd, stall, fetch_err} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {mem_rd, stall, fetch_err}); end
    checks++;
    if ({instr, instr_pc, mem_addr} !== 48'h0) begin errors++; $display("[TB] FAIL reset_regs: got %h expected 0", {instr, instr_pc, mem_addr}); end
    INCR_PC = 1'b0; BE = 1'b0; mem_ready = 1'b0; reset = 1'b1;
  endtask

  task automatic test_zero_wait();
    // mem_ready high in IDLE must not load instr.
    IR_LOAD = 1'b1; mem_ready = 1'b1; mem_rdata = 16'hA5C3;
    step();
    IR_LOAD = 1'b0;
    checks++;
    if ({mem_rd, stall} !== 2'b11) begin errors++; $display("[TB] FAIL zw_req: got %b expected 11", {mem_rd, stall}); end
    checks++;
    if (mem_addr !== 16'h0000 || instr !== 16'h0000) begin errors++; $display("[TB] FAIL zw_addr: got addr %h instr %h expected 0000 0000", mem_addr, instr); end
    step();
    mem_ready = 1'b0;
    checks++;
    if ({mem_rd, stall} !== 2'b00) begin errors++; $display("[TB] FAIL zw_done: got %b expected 00", {mem_rd, stall}); end
    checks++;
    if (instr !== 16'hA5C3 || instr_pc !== 16'h0000) begin errors++; $display("[TB] FAIL zw_instr: got %h@%h expected a5c3@0000", instr, instr_pc); end
  endtask

  task automatic test_wait_states();
    BE = 1'b1; target = 16'h0010;
    step();
    BE = 1'b0;
    checks++;
    if (pc !== 16'h0010) begin errors++; $display("[TB] FAIL ws_branch: got %h expected 0010", pc); end
    IR_LOAD = 1'b1; mem_ready = 1'b0;
    step();
    IR_LOAD = 1'b0;
    for (int i = 0; i < 3; i++) begin
      INCR_PC = 1'b1;
      step();
      checks++;
      if (mem_addr !== 16'h0010 || mem_rd !== 1'b1) begin errors++; $display("[TB] FAIL ws_hold%0d: got addr %h rd %b expected 0010 1", i, mem_addr, mem_rd); end
    end
    INCR_PC = 1'b0; mem_ready = 1'b1; mem_rdata = 16'h1234;
    step();
    mem_ready = 1'b0;
    checks++;
    if (instr !== 16'h1234 || instr_pc !== 16'h0010) begin errors++; $display("[TB] FAIL ws_instr: got %h@%h expected 1234@0010", instr, instr_pc); end
    checks++;
    if (pc !== 16'h0013 || mem_rd !== 1'b0) begin errors++; $display("[TB] FAIL ws_pc: got pc %h rd %b expected 0013 0", pc, mem_rd); end
  endtask

  task automatic test_timeout();
    int cnt;
    IR_LOAD = 1'b1; mem_ready = 1'b0;
    step();
    IR_LOAD = 1'b0;
    cnt = 0;
    while (mem_rd === 1'b1 && cnt < 40) begin
      cnt++;
      step();
    end
    checks++;
    if (cnt != 16) begin errors++; $display("[TB] FAIL to_cycles: got %0d expected 16", cnt); end
    checks++;
    if (instr !== 16'h0000 || fetch_err !== 1'b1 || stall !== 1'b0) begin errors++; $display("[TB] FAIL to_result: got instr %h err %b stall %b expected 0000 1 0", instr, fetch_err, stall); end
    IR_LOAD = 1'b1;
    step();
    IR_LOAD = 1'b0; mem_ready = 1'b1; mem_rdata = 16'hBEEF;
    step();
    mem_ready = 1'b0;
    checks++;
    if (instr !== 16'hBEEF || fetch_err !== 1'b1) begin errors++; $display("[TB] FAIL to_refetch: got instr %h err %b expected beef 1", instr, fetch_err); end
  endtask

  task automatic test_branch_wrap();
    BE = 1'b1; target = 16'hFFFF;
    step();
    BE = 1'b0; INCR_PC = 1'b1;
    step();
    checks++;
    if (pc !== 16'h0000) begin errors++; $display("[TB] FAIL br_wrap: got %h expected 0000", pc); end
    BE = 1'b1; target = 16'h0200;
    step();
    checks++;
    if (pc !== 16'h0200) begin errors++; $display("[TB] FAIL br_priority: got %h expected 0200", pc); end
    BE = 1'b0; INCR_PC = 1'b0;
    step();
    checks++;
    if (pc !== 16'h0200 || fetch_err !== 1'b1) begin errors++; $display("[TB] FAIL br_hold: got pc %h err %b expected 0200 1", pc, fetch_err); end
  endtask

  task automatic test_reset_mid_fetch();
    IR_LOAD = 1'b1; mem_ready = 1'b0;
    step();
    IR_LOAD = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
    checks++;
    if ({mem_rd, stall, fetch_err} !== 3'b000) begin errors++; $display("[TB] FAIL rst_flags: got %b expected 000", {mem_rd, stall, fetch_err}); end
    checks++;
    if (pc !== 16'h0000 || instr !== 16'h0000 || mem_addr !== 16'h0000) begin errors++; $display("[TB] FAIL rst_regs: got pc %h instr %h addr %h expected 0", pc, instr, mem_addr); end
    // First released edge fetches normally; INCR_PC on the same edge uses old pc.
    reset = 1'b1; IR_LOAD = 1'b1; INCR_PC = 1'b1;
    step();
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 16'h0000 || pc !== 16'h0001) begin errors++; $display("[TB] FAIL rst_release: got rd %b addr %h pc %h expected 1 0000 0001", mem_rd, mem_addr, pc); end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (mem_rd !== 1'b1 || mem_addr !== 16'h0000) begin errors++; $display("[TB] FAIL ign_load%0d: got rd %b addr %h expected 1 0000", i, mem_rd, mem_addr); end
    end
    IR_LOAD = 1'b0; INCR_PC = 1'b0; mem_ready = 1'b1; mem_rdata = 16'h5A5A;
    step();
    checks++;
    if (instr !== 16'h5A5A || instr_pc !== 16'h0000 || pc !== 16'h0003) begin errors++; $display("[TB] FAIL ign_capture: got %h@%h pc %h expected 5a5a@0000 0003", instr, instr_pc, pc); end
    mem_rdata = 16'hFFFF;
    step();
    mem_ready = 1'b0;
    checks++;
    if (instr !== 16'h5A5A || mem_rd !== 1'b0) begin errors++; $display("[TB] FAIL no_queue: got instr %h rd %b expected 5a5a 0", instr, mem_rd); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_timeout();
    test_branch_wrap();
    test_reset_mid_fetch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
